instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2: prefetch buffer entries, legal range 2..8.
REQ-002 The block SHALL have parameter PC_RESET, default 8'h00: first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port imem_addr  output  8: byte address driven to instruction memory.
REQ-006 The block SHALL have port imem_ins  input  16: instruction returned combinationally for imem_addr, as {byte[addr], byte[addr+1]}.
REQ-007 The block SHALL have port ins_valid  output  1: buffer head holds a valid instruction.
REQ-008 The block SHALL have port ins_ready  input  1: consumer accepts the head this cycle.
REQ-009 The block SHALL have port ins_data  output  16: head instruction.
REQ-010 The block SHALL have port ins_pc  output  8: address the head instruction was fetched from.
REQ-011 The block SHALL have port redirect_valid  input  1: branch/jump request.
REQ-012 The block SHALL have port redirect_pc  input  8: new fetch address.
REQ-013 The block SHALL have port fifo_count  output  4: number of occupied buffer entries.
REQ-014 The block SHALL have port halted  output  1: fetch stopped on halt instruction (held 0 when the halt feature is compiled out).

Function
REQ-015 imem_addr SHALL equal the fetch PC register at all times.
REQ-016 A fetch SHALL occur in a cycle when not halted, redirect_valid=0, and (fifo_count<DEPTH or a pop occurs that cycle); the entry {pc, imem_ins} is pushed and pc advances by 2.
REQ-017 A pop SHALL occur when ins_valid and ins_ready are both 1; ins_valid SHALL NOT depend combinationally on ins_ready.
REQ-018 PC arithmetic SHALL be 8-bit modulo: 8'hFE+2 -> 8'h00, 8'hFF+2 -> 8'h01.
REQ-019 Fetch-to-valid latency SHALL be one cycle: an instruction pushed at edge N is visible on ins_data after edge N when the buffer was empty.
REQ-020 When full with no pop, pc and buffer SHALL hold unchanged.
REQ-021 redirect_valid=1 SHALL, at that edge, flush all entries (fifo_count->0), set pc<=redirect_pc, clear halted, and suppress both push and pop that cycle; ins_valid SHALL be 0 the following cycle.
REQ-022 Odd redirect_pc SHALL be accepted; fetch then proceeds on odd addresses.
REQ-023 Buffer order SHALL be strictly FIFO; simultaneous push and pop on a full buffer SHALL keep fifo_count at DEPTH.

Reset
REQ-024 On rst_n=0, asynchronously: pc=PC_RESET, fifo_count=0, ins_valid=0, halted=0, ins_data=16'h0000, ins_pc=8'h00.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries; first fetch occurs on the first edge after rst_n deasserts.

Configuration
REQ-026 With macro IFETCH_HALT_DETECT_EN defined, a fetched instruction equal to 16'h0000 SHALL be pushed, then halted<=1 and fetching SHALL stop until redirect or reset.
REQ-027 Without IFETCH_HALT_DETECT_EN, 16'h0000 SHALL be treated as an ordinary instruction and halted tied to 0.

Structure
REQ-028 Package simplecpu_pkg SHALL hold ADDR_W=8, INS_W=16, NOP_INS=16'h0000 and typedef fetch_entry_t {pc, ins}.
REQ-029 The buffer SHALL be a sub-module ifetch_fifo (parameter DEPTH, flush input, count output).

Verification
REQ-030 Reset release, memory bytes 0..3 = 12 34 56 78, ins_ready=1 -> ins_data 16'h1234 pc 00, then 16'h5678 pc 02 on consecutive cycles.
REQ-031 ins_ready=0 for 5 cycles -> fifo_count saturates at 2, imem_addr holds at 8'h04; release -> order 00,02,04 preserved.
REQ-032 redirect_valid=1, redirect_pc=8'h40 while buffer full -> next cycle fifo_count=0, ins_valid=0, imem_addr=8'h40; then ins_pc=8'h40.
REQ-033 redirect_pc=8'hFE -> ins_pc sequence FE, 00, 02 (wrap).
REQ-034 IFETCH_HALT_DETECT_EN defined, word at 8'h06 = 16'h0000 -> instruction at 06 delivered, halted=1, imem_addr stays 8'h08; redirect to 8'h00 clears halted.
REQ-035 rst_n pulsed low mid-stream with fifo_count=2 -> immediately fifo_count=0, ins_valid=0, imem_addr=PC_RESET.

Source files
------------

// File: rtl/simplecpu_pkg.sv
// Shared widths and the prefetch entry layout for the fetch unit.
package simplecpu_pkg;
  localparam int ADDR_W = 8;
  localparam int INS_W  = 16;
  localparam int ENTRY_W = ADDR_W + INS_W;
  localparam logic [INS_W-1:0] NOP_INS = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// Circular prefetch buffer; head is read combinationally from storage.
// Push into a full buffer is legal only together with a pop (slot is recycled).
module ifetch_fifo
  import simplecpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_dat,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [3:0]         count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + {3'b000, push} - {3'b000, pop};
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction prefetcher feeding a valid/ready consumer; 1-cycle fetch-to-valid.
// Optional halt-on-zero-word detection is enabled by defining IFETCH_HALT_DETECT_EN.
module instr_fetch_unit
  import simplecpu_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [15:0] ins_data,
  output logic [7:0]  ins_pc,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic [3:0]  fifo_count,
  output logic        halted
);
  logic [ADDR_W-1:0]  pc;
  logic               halt_q;
  logic               pop;
  logic               fetch;
  logic [ENTRY_W-1:0] head_raw;
  fetch_entry_t       head;
  fetch_entry_t       new_entry;

  assign imem_addr = pc;
  assign ins_valid = (fifo_count != 4'd0);
  assign pop       = ins_valid & ins_ready & ~redirect_valid;
  // A pop frees a slot in the same cycle, so a full buffer still streams.
  assign fetch     = ~halt_q & ~redirect_valid & ((fifo_count < 4'(DEPTH)) | pop);
  assign new_entry = '{pc: pc, ins: imem_ins};
  assign head      = head_raw;
  assign ins_data  = head.ins;
  assign ins_pc    = head.pc;
  assign halted    = halt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= PC_RESET;
    else if (redirect_valid) pc <= redirect_pc;
    else if (fetch)          pc <= pc + 8'd2;
  end

`ifdef IFETCH_HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            halt_q <= 1'b0;
    else if (redirect_valid)               halt_q <= 1'b0;
    else if (fetch && imem_ins == NOP_INS) halt_q <= 1'b1;
  end
`else
  assign halt_q = 1'b0;
`endif

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (fetch),
    .push_dat (new_entry),
    .pop      (pop),
    .head     (head_raw),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_instr_fetch_unit;
  localparam int         DEPTH    = 2;
  localparam logic [7:0] PC_RESET = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  imem_addr;
  logic [15:0] imem_ins;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [15:0] ins_data;
  logic [7:0]  ins_pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [3:0]  fifo_count;
  logic        halted;

  logic [7:0]  mem [256];
  logic [23:0] m_q [$];
  logic [7:0]  m_pc;
  logic        m_halted;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  assign imem_ins = {mem[imem_addr], mem[imem_addr + 8'd1]};

  instr_fetch_unit #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_ins(imem_ins),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_pc(ins_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fifo_count(fifo_count), .halted(halted)
  );

  function automatic logic [15:0] word_at(input logic [7:0] a);
    logic [7:0] b;
    b = a + 8'd1;
    return {mem[a], mem[b]};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pc = PC_RESET;
    m_halted = 1'b0;
  endfunction

  // Reference: a bounded queue of {pc, word}; redirect wins over everything.
  function automatic void model_step(input logic rdy, input logic rv, input logic [7:0] rpc);
    logic        do_pop;
    logic        do_fetch;
    logic [15:0] w;
    do_pop = (m_q.size() > 0) && rdy && !rv;
    if (rv) begin
      m_q.delete();
      m_pc = rpc;
      m_halted = 1'b0;
    end else begin
      do_fetch = !m_halted && ((m_q.size() < DEPTH) || do_pop);
      w = word_at(m_pc);
      if (do_pop) void'(m_q.pop_front());
      if (do_fetch) begin
        m_q.push_back({m_pc, w});
`ifdef IFETCH_HALT_DETECT_EN
        if (w == 16'h0000) m_halted = 1'b1;
`endif
        m_pc = m_pc + 8'd2;
      end
    end
  endfunction

  task automatic cycle(input logic rdy, input logic rv, input logic [7:0] rpc);
    ins_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    model_step(rdy, rv, rpc);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    ins_ready = 1'b0;
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) + 8'h11;
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (ins_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ins_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (ins_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", ins_data); end
    checks++; if (ins_pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", ins_pc); end
    checks++; if (imem_addr !== PC_RESET) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, PC_RESET); end
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_valid !== 1'b1 || ins_data !== 16'h1234 || ins_pc !== 8'h00) begin
      failures++; $display("FAIL basic_first got=%b/%h/%h exp=1/1234/00", ins_valid, ins_data, ins_pc); end
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_valid !== 1'b1 || ins_data !== 16'h5678 || ins_pc !== 8'h02) begin
      failures++; $display("FAIL basic_second got=%b/%h/%h exp=1/5678/02", ins_valid, ins_data, ins_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) cycle(1'b0, 1'b0, 8'h00);
    checks++; if (fifo_count !== 4'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", fifo_count); end
    checks++; if (imem_addr !== 8'h04) begin failures++; $display("FAIL stall_addr got=%h exp=04", imem_addr); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ins_pc !== 8'(2 * k) || ins_valid !== 1'b1) begin
        failures++; $display("FAIL stall_order got=%h exp=%h", ins_pc, 8'(2 * k)); end
      cycle(1'b1, 1'b0, 8'h00);
    end
    checks++; if (fifo_count !== 4'd2) begin failures++; $display("FAIL full_pushpop_count got=%0d exp=2", fifo_count); end
  endtask

  task automatic test_redirect();
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h40);
    checks++; if (fifo_count !== 4'd0 || ins_valid !== 1'b0 || imem_addr !== 8'h40) begin
      failures++; $display("FAIL redirect_flush got=%0d/%b/%h exp=0/0/40", fifo_count, ins_valid, imem_addr); end
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_pc !== 8'h40 || ins_valid !== 1'b1 || ins_data !== word_at(8'h40)) begin
      failures++; $display("FAIL redirect_target got=%h/%b exp=40/1", ins_pc, ins_valid); end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b1, 8'hFE);
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_pc !== 8'hFE || imem_addr !== 8'h00) begin
      failures++; $display("FAIL wrap_fe got=%h/%h exp=fe/00", ins_pc, imem_addr); end
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_pc !== 8'h00) begin failures++; $display("FAIL wrap_00 got=%h exp=00", ins_pc); end
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_pc !== 8'h02) begin failures++; $display("FAIL wrap_02 got=%h exp=02", ins_pc); end
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_pc !== 8'hFF || imem_addr !== 8'h01 || ins_data !== {mem[8'hFF], mem[8'h00]}) begin
      failures++; $display("FAIL wrap_odd got=%h/%h/%h exp=ff/01", ins_pc, imem_addr, ins_data); end
    cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_pc !== 8'h01 || ins_data !== word_at(8'h01)) begin
      failures++; $display("FAIL odd_stream got=%h/%h exp=01/%h", ins_pc, ins_data, word_at(8'h01)); end
  endtask

  task automatic test_halt();
    mem[6] = 8'h00; mem[7] = 8'h00;
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 8'h00);
    checks++; if (ins_pc !== 8'h06 || ins_data !== 16'h0000 || ins_valid !== 1'b1) begin
      failures++; $display("FAIL halt_word got=%h/%h exp=06/0000", ins_pc, ins_data); end
    cycle(1'b1, 1'b0, 8'h00);
`ifdef IFETCH_HALT_DETECT_EN
    checks++; if (halted !== 1'b1 || imem_addr !== 8'h08 || ins_valid !== 1'b0) begin
      failures++; $display("FAIL halt_stop got=%b/%h/%b exp=1/08/0", halted, imem_addr, ins_valid); end
    cycle(1'b1, 1'b1, 8'h00);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear got=%b exp=0", halted); end
`else
    checks++; if (halted !== 1'b0 || imem_addr !== 8'h0A || ins_pc !== 8'h08) begin
      failures++; $display("FAIL nohalt got=%b/%h/%h exp=0/0a/08", halted, imem_addr, ins_pc); end
`endif
    mem[6] = 8'h17; mem[7] = 8'h18;
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    checks++; if (fifo_count !== 4'd2) begin failures++; $display("FAIL midrst_pre got=%0d exp=2", fifo_count); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (fifo_count !== 4'd0 || ins_valid !== 1'b0 || imem_addr !== PC_RESET) begin
      failures++; $display("FAIL midrst_async got=%0d/%b/%h exp=0/0/%h", fifo_count, ins_valid, imem_addr, PC_RESET); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    checks++; if (fifo_count !== 4'd1 || ins_pc !== PC_RESET) begin
      failures++; $display("FAIL midrst_first got=%0d/%h exp=1/%h", fifo_count, ins_pc, PC_RESET); end
  endtask

  task automatic test_random();
    logic rdy;
    logic rv;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h20] = 8'h00; mem[8'h21] = 8'h00;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 24) == 0);
      cycle(rdy, rv, (n % 50 == 7) ? 8'h1C : 8'($urandom));
      checks++; if (fifo_count !== 4'(m_q.size()) || ins_valid !== (m_q.size() != 0)) begin
        failures++; $display("FAIL rnd_count n=%0d got=%0d/%b exp=%0d", n, fifo_count, ins_valid, m_q.size()); end
      checks++; if (imem_addr !== m_pc || halted !== m_halted) begin
        failures++; $display("FAIL rnd_pc n=%0d got=%h/%b exp=%h/%b", n, imem_addr, halted, m_pc, m_halted); end
      if (m_q.size() != 0) begin
        checks++; if ({ins_pc, ins_data} !== m_q[0]) begin
          failures++; $display("FAIL rnd_head n=%0d got=%h exp=%h", n, {ins_pc, ins_data}, m_q[0]); end
      end
    end
  endtask

  initial begin
    init_mem();
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
